// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter level: conditional shift by SHIFT_BY, a register slice and
// bubble-collapsing valid/ready.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SHIFT_BY = 1,
    localparam int unsigned AMT_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_data,
    input  logic [AMT_W-1:0] up_amt,
    input  shift_mode_t      up_mode,
    input  logic             down_adv,
    output logic             adv,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic [AMT_W-1:0] amt,
    output shift_mode_t      mode
);

    localparam int unsigned BIT = $clog2(SHIFT_BY);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    shift_mode_t      mode_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_d;

    // SRA uses the current MSB: earlier levels already replicated the original sign there.
    always_comb begin
        shifted = up_data;
        unique case (up_mode)
            SLL: shifted = up_data << SHIFT_BY;
            SRL: shifted = up_data >> SHIFT_BY;
            SRA: shifted = $signed(up_data) >>> SHIFT_BY;
            ROL: shifted = (up_data << SHIFT_BY) | (up_data >> (WIDTH - SHIFT_BY));
        endcase
        data_d = up_amt[BIT] ? shifted : up_data;
    end

    assign adv = !vld_q || down_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= SLL;
        end else if (adv) begin
            vld_q <= up_vld;
            if (up_vld) begin
                data_q <= data_d;
                amt_q  <= up_amt;
                mode_q <= up_mode;
            end
        end
    end

    assign vld  = vld_q;
    assign data = data_q;
    assign amt  = amt_q;
    assign mode = mode_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one shifter_stage per amount bit, valid/ready on both ends,
// in-order with bubble collapsing.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amt,
    input  shift_mode_t      mode,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned L = AMT_W;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        shift_mode_t      mode;
    } stage_t;

    // stg[0] is the incoming op, stg[k+1] the register contents of stage k.
    stage_t     stg [L+1];
    logic [L:0] adv;
    logic       unused_tail;

    assign stg[0] = '{vld: in_vld, data: src, amt: amt, mode: mode};
    assign adv[L] = out_rdy;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [AMT_W-1:0] amt_q;
        shift_mode_t      mode_q;

        shifter_stage #(
            .WIDTH   (WIDTH),
            .SHIFT_BY(1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_vld  (stg[k].vld),
            .up_data (stg[k].data),
            .up_amt  (stg[k].amt),
            .up_mode (stg[k].mode),
            .down_adv(adv[k+1]),
            .adv     (adv[k]),
            .vld     (vld_q),
            .data    (data_q),
            .amt     (amt_q),
            .mode    (mode_q)
        );

        assign stg[k+1] = '{vld: vld_q, data: data_q, amt: amt_q, mode: mode_q};
    end

    assign in_rdy  = adv[0];
    assign out_vld = stg[L].vld;
    assign res     = stg[L].data;

    assign unused_tail = ^{stg[L].amt, stg[L].mode};

endmodule
